vga_quad_master: RTL and testbench

Parametrised VGA timing master and 4-quadrant pixel processor. It drives the display from four independent quadrant frame buffers. Each quadrant has a runtime-selectable mode (colour, grayscale, binary with programmable threshold, blank), latched at frame boundaries so a mode change never splits a frame. Outputs are fully registered, and syncs are delay-matched to the 2-stage pixel pipeline.

---
 rtl/vga_quad_master.sv | 260 ++++++++++++++++++++++++++
 tb/tb_vga_quad_master.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_quad_master.sv
// VGA timing master driving four quadrant frame buffers. Each quadrant
// has its own display mode (colour, gray, binary, blank). The mode and the
// binary threshold are latched only at end of frame. RGB, syncs and de
// leave a 2-stage pipeline together.
module vga_quad_master #(
    parameter int   H_DISPLAY = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_PULSE   = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_DISPLAY = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_PULSE   = 2,
    parameter int   V_BACK    = 29,
    parameter int   CH_W      = 4,
    parameter int   ADDR_W    = 17,
    parameter logic SYNC_ACT  = 1'b0
) (
    input  logic                vga_clk25,
    input  logic                vga_rst,
    input  logic [7:0]          mode_cfg,
    input  logic [CH_W-1:0]     bin_thresh,
    input  logic [3*CH_W-1:0]   vga_data0,
    input  logic [3*CH_W-1:0]   vga_data1,
    input  logic [3*CH_W-1:0]   vga_data2,
    input  logic [3*CH_W-1:0]   vga_data3,
    output logic [ADDR_W-1:0]   vga_addr0,
    output logic [ADDR_W-1:0]   vga_addr1,
    output logic [ADDR_W-1:0]   vga_addr2,
    output logic [ADDR_W-1:0]   vga_addr3,
    output logic [CH_W-1:0]     vga_red,
    output logic [CH_W-1:0]     vga_green,
    output logic [CH_W-1:0]     vga_blue,
    output logic                vga_hsync,
    output logic                vga_vsync,
    output logic                vga_de,
    output logic                frame_start,
    output logic [3:0]          region
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_PULSE + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_PULSE + V_BACK;
    localparam int QPIX    = (H_DISPLAY / 2) * (V_DISPLAY / 2);
    // One spare bit so that the sync end bound can never alias to zero.
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT     = HW'(H_DISPLAY);
    localparam logic [HW-1:0] H_MID     = HW'(H_DISPLAY / 2);
    localparam logic [HW-1:0] H_SYNC_ON = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] H_SYNC_OF = HW'(H_DISPLAY + H_FRONT + H_PULSE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT     = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_MID     = VW'(V_DISPLAY / 2);
    localparam logic [VW-1:0] V_SYNC_ON = VW'(V_DISPLAY + V_FRONT);
    localparam logic [VW-1:0] V_SYNC_OF = VW'(V_DISPLAY + V_FRONT + V_PULSE);
    localparam logic [ADDR_W-1:0] Q_LAST = ADDR_W'(QPIX - 1);

    // ---------------- stage 0: raster counters ----------------
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic          end_of_frame;
    logic [3:0]    region_c;
    logic          hs_raw, vs_raw, de_raw;

    // Next raster position: hcnt wraps each line, vcnt steps on that wrap.
    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end
    end

    // Raster counter registers.
    always_ff @(posedge vga_clk25 or posedge vga_rst) begin
        if (vga_rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
        end
    end

    // Stage-0 decode: quadrant membership, raw syncs, display enable.
    always_comb begin
        logic h_act, v_act, h_right, v_bot;
        h_act   = (hcnt_q < H_ACT);
        v_act   = (vcnt_q < V_ACT);
        h_right = (hcnt_q >= H_MID);
        v_bot   = (vcnt_q >= V_MID);
        de_raw  = h_act && v_act;
        region_c[0] = de_raw && !h_right && !v_bot;
        region_c[1] = de_raw &&  h_right && !v_bot;
        region_c[2] = de_raw && !h_right &&  v_bot;
        region_c[3] = de_raw &&  h_right &&  v_bot;
        hs_raw = ((hcnt_q >= H_SYNC_ON) && (hcnt_q < H_SYNC_OF)) ? SYNC_ACT : ~SYNC_ACT;
        vs_raw = ((vcnt_q >= V_SYNC_ON) && (vcnt_q < V_SYNC_OF)) ? SYNC_ACT : ~SYNC_ACT;
        end_of_frame = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);
    end

    assign region      = region_c;
    assign frame_start = (hcnt_q == '0) && (vcnt_q == '0);

    // ---------------- per-quadrant address counters ----------------
    logic [ADDR_W-1:0] addr_vec [4];
    logic [3*CH_W-1:0] data_vec [4];

    assign data_vec[0] = vga_data0;
    assign data_vec[1] = vga_data1;
    assign data_vec[2] = vga_data2;
    assign data_vec[3] = vga_data3;

    for (genvar gi = 0; gi < 4; gi++) begin : g_quad
        logic [ADDR_W-1:0] addr_q, addr_d;

        // Address steps through the quadrant raster; restarts every frame.
        always_comb begin
            addr_d = addr_q;
            if (end_of_frame)
                addr_d = '0;
            else if (region_c[gi])
                addr_d = (addr_q == Q_LAST) ? '0 : addr_q + ADDR_W'(1);
        end

        // Address register.
        always_ff @(posedge vga_clk25 or posedge vga_rst) begin
            if (vga_rst) addr_q <= '0;
            else         addr_q <= addr_d;
        end

        assign addr_vec[gi] = addr_q;
    end

    assign vga_addr0 = addr_vec[0];
    assign vga_addr1 = addr_vec[1];
    assign vga_addr2 = addr_vec[2];
    assign vga_addr3 = addr_vec[3];

    // ---------------- shadow configuration ----------------
    logic [7:0]      mode_sh_q;
    logic [CH_W-1:0] thr_sh_q;

    // Mode and threshold only change between frames so no frame is split.
    always_ff @(posedge vga_clk25 or posedge vga_rst) begin
        if (vga_rst) begin
            mode_sh_q <= 8'b10_01_01_00;
            thr_sh_q  <= CH_W'(8);
        end else if (end_of_frame) begin
            mode_sh_q <= mode_cfg;
            thr_sh_q  <= bin_thresh;
        end
    end

    // ---------------- stage 1 ----------------
    logic [1:0] mode_sel;
    logic [3:0] region_s1_q;
    logic [1:0] mode_s1_q;
    logic       hs_s1_q, vs_s1_q, de_s1_q;

    // Pick the shadow mode of whichever quadrant is active (blank if none).
    always_comb begin
        mode_sel = 2'b11;
        for (int i = 0; i < 4; i++)
            if (region_c[i]) mode_sel = mode_sh_q[2*i +: 2];
    end

    // Stage-1 pipeline: waits out the one-cycle RAM read latency.
    always_ff @(posedge vga_clk25 or posedge vga_rst) begin
        if (vga_rst) begin
            region_s1_q <= '0;
            mode_s1_q   <= 2'b11;
            hs_s1_q     <= ~SYNC_ACT;
            vs_s1_q     <= ~SYNC_ACT;
            de_s1_q     <= 1'b0;
        end else begin
            region_s1_q <= region_c;
            mode_s1_q   <= mode_sel;
            hs_s1_q     <= hs_raw;
            vs_s1_q     <= vs_raw;
            de_s1_q     <= de_raw;
        end
    end

    // ---------------- stage 2 ----------------
    logic [3*CH_W-1:0] data_sel;
    logic [CH_W-1:0]   ch_r, ch_g, ch_b, gray;
    logic [CH_W+1:0]   luma_sum;
    logic [CH_W-1:0]   red_d, green_d, blue_d;
    logic [CH_W-1:0]   red_q, green_q, blue_q;
    logic              hs_s2_q, vs_s2_q, de_s2_q;

    // Pixel processing on the RAM word of the stage-1 quadrant.
    always_comb begin
        data_sel = '0;
        for (int i = 0; i < 4; i++)
            if (region_s1_q[i]) data_sel = data_vec[i];
        ch_r     = data_sel[3*CH_W-1 -: CH_W];
        ch_g     = data_sel[2*CH_W-1 -: CH_W];
        ch_b     = data_sel[CH_W-1:0];
        luma_sum = {2'b00, ch_r} + {1'b0, ch_g, 1'b0} + {2'b00, ch_b};
        gray     = luma_sum[CH_W+1:2];
        red_d    = '0;
        green_d  = '0;
        blue_d   = '0;
        if (region_s1_q != 4'b0000) begin
            case (mode_s1_q)
                2'b00: begin
                    red_d   = ch_r;
                    green_d = ch_g;
                    blue_d  = ch_b;
                end
                2'b01: begin
                    red_d   = gray;
                    green_d = gray;
                    blue_d  = gray;
                end
                2'b10: begin
                    red_d   = (gray > thr_sh_q) ? '1 : '0;
                    green_d = (gray > thr_sh_q) ? '1 : '0;
                    blue_d  = (gray > thr_sh_q) ? '1 : '0;
                end
                default: begin
                    red_d   = '0;
                    green_d = '0;
                    blue_d  = '0;
                end
            endcase
        end
    end

    // Stage-2 output registers; syncs and de travel with the pixel.
    always_ff @(posedge vga_clk25 or posedge vga_rst) begin
        if (vga_rst) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hs_s2_q <= ~SYNC_ACT;
            vs_s2_q <= ~SYNC_ACT;
            de_s2_q <= 1'b0;
        end else begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
            hs_s2_q <= hs_s1_q;
            vs_s2_q <= vs_s1_q;
            de_s2_q <= de_s1_q;
        end
    end

    assign vga_red   = red_q;
    assign vga_green = green_q;
    assign vga_blue  = blue_q;
    assign vga_hsync = hs_s2_q;
    assign vga_vsync = vs_s2_q;
    assign vga_de    = de_s2_q;

endmodule

// File: tb/tb_vga_quad_master.sv
// Bench for vga_quad_master on a reduced raster (24x12 total, 16x8 active).
// Expected values come from a reference model computed from raster position.
module tb_vga_quad_master;

    localparam int HD = 16, HF = 2, HP = 3, HB = 3;
    localparam int VD = 8,  VF = 1, VP = 2, VB = 1;
    localparam int HT = HD + HF + HP + HB;
    localparam int VT = VD + VF + VP + VB;
    localparam int FRAME = HT * VT;
    localparam int HH = HD / 2, VH = VD / 2;
    localparam int QPIX = HH * VH;
    localparam int CW = 4, AW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    mode_cfg = 8'h00;
    logic [CW-1:0] bin_thresh = 4'd0;
    logic [11:0]   data0, data1, data2, data3;
    logic [AW-1:0] addr0, addr1, addr2, addr3;
    logic [CW-1:0] red, green, blue;
    logic          hs, vs, de, fs;
    logic [3:0]    region;

    vga_quad_master #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_PULSE(HP), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_PULSE(VP), .V_BACK(VB),
        .CH_W(CW), .ADDR_W(AW), .SYNC_ACT(1'b0)
    ) dut (
        .vga_clk25(clk), .vga_rst(rst), .mode_cfg(mode_cfg), .bin_thresh(bin_thresh),
        .vga_data0(data0), .vga_data1(data1), .vga_data2(data2), .vga_data3(data3),
        .vga_addr0(addr0), .vga_addr1(addr1), .vga_addr2(addr2), .vga_addr3(addr3),
        .vga_red(red), .vga_green(green), .vga_blue(blue),
        .vga_hsync(hs), .vga_vsync(vs), .vga_de(de),
        .frame_start(fs), .region(region)
    );

    always #5 clk = ~clk;

    // Quadrant frame buffers with a one-cycle registered read.
    logic [11:0] mem [4][QPIX];
    always @(posedge clk) begin
        data0 <= (addr0 < AW'(QPIX)) ? mem[0][addr0[4:0]] : 12'h000;
        data1 <= (addr1 < AW'(QPIX)) ? mem[1][addr1[4:0]] : 12'h000;
        data2 <= (addr2 < AW'(QPIX)) ? mem[2][addr2[4:0]] : 12'h000;
        data3 <= (addr3 < AW'(QPIX)) ? mem[3][addr3[4:0]] : 12'h000;
    end

    int n_vec = 0;
    int n_err = 0;
    int k = 0;          // clock edges since reset release
    int fm [8];         // mode in force for each frame since release
    int ft [8];         // threshold in force for each frame since release

    // ---------------- reference model ----------------
    function automatic int clampi(int x, int lo, int hi);
        if (x < lo) return lo;
        if (x > hi) return hi;
        return x;
    endfunction

    // {r,g,b,de,hsync,vsync} expected after kk edges (pixel kk-2).
    function automatic logic [14:0] exp_out(int kk);
        int p, f, pos, h, v, q, idx, m, r, g, b, y, ro, go, bo;
        logic de_e, hs_e, vs_e;
        logic [11:0] px;
        if (kk < 2) return {12'h000, 1'b0, 1'b1, 1'b1};
        p = kk - 2; f = p / FRAME; pos = p % FRAME;
        h = pos % HT; v = pos / HT;
        de_e = (h < HD) && (v < VD);
        hs_e = !((h >= HD + HF) && (h < HD + HF + HP));
        vs_e = !((v >= VD + VF) && (v < VD + VF + VP));
        ro = 0; go = 0; bo = 0;
        if (de_e) begin
            q   = ((h >= HH) ? 1 : 0) + ((v >= VH) ? 2 : 0);
            idx = (v % VH) * HH + (h % HH);
            px  = mem[q][idx];
            r = int'(px[11:8]); g = int'(px[7:4]); b = int'(px[3:0]);
            m = (fm[f] >> (2 * q)) & 3;
            y = (r + 2 * g + b) / 4;
            case (m)
                0: begin ro = r; go = g; bo = b; end
                1: begin ro = y; go = y; bo = y; end
                2: begin ro = (y > ft[f]) ? 15 : 0; go = ro; bo = ro; end
                default: begin ro = 0; go = 0; bo = 0; end
            endcase
        end
        return {4'(ro), 4'(go), 4'(bo), de_e, hs_e, vs_e};
    endfunction

    // {region, frame_start} for the counter position after kk edges.
    function automatic logic [4:0] exp_rf(int kk);
        int pos, h, v;
        logic [3:0] rg;
        pos = kk % FRAME; h = pos % HT; v = pos / HT;
        rg = 4'b0000;
        if (h < HD && v < VD) rg[((h >= HH) ? 1 : 0) + ((v >= VH) ? 2 : 0)] = 1'b1;
        return {rg, pos == 0};
    endfunction

    // Addresses = quadrant pixels already scanned this frame, modulo QPIX.
    function automatic logic [31:0] exp_addrs(int kk);
        int pos, h, v, h0, v0, rows, part;
        logic [31:0] res;
        pos = kk % FRAME; h = pos % HT; v = pos / HT;
        res = '0;
        for (int q = 0; q < 4; q++) begin
            h0 = (q % 2) * HH; v0 = (q / 2) * VH;
            rows = clampi(v - v0, 0, VH);
            part = (v >= v0 && v < v0 + VH) ? clampi(h - h0, 0, HH) : 0;
            res[8*q +: 8] = 8'((rows * HH + part) % QPIX);
        end
        return res;
    endfunction

    // ---------------- stimulus plumbing ----------------
    task automatic tick();
        if (k % FRAME == FRAME - 1 && k / FRAME + 1 < 8) begin
            fm[k / FRAME + 1] = int'(mode_cfg);
            ft[k / FRAME + 1] = int'(bin_thresh);
        end
        @(posedge clk); #1;
        k++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 0;
        fm[0] = 8'h94;
        ft[0] = 8;
    endtask

    task automatic fill_random();
        for (int q = 0; q < 4; q++)
            for (int i = 0; i < QPIX; i++) mem[q][i] = 12'($urandom);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mode_cfg = 8'($urandom);
            @(posedge clk); #1;
            n_vec++;
            if ({red, green, blue, de, hs, vs} !== 15'b0000_0000_0000_0_1_1) begin
                n_err++;
                $display("FAIL reset_out got %h required %h", {red, green, blue, de, hs, vs}, 15'h0003);
            end
            n_vec++;
            if ({region, fs} !== 5'b0001_1) begin
                n_err++;
                $display("FAIL reset_region got %b required 00011", {region, fs});
            end
            n_vec++;
            if ({addr3, addr2, addr1, addr0} !== 32'h0) begin
                n_err++;
                $display("FAIL reset_addr got %h required 0", {addr3, addr2, addr1, addr0});
            end
        end
        $display("test_reset done");
    endtask

    // Model-checked run of n cycles; optional random config changes.
    task automatic test_timing_run(int n, bit rand_cfg, string tag);
        logic [14:0] eo;
        logic [4:0]  er;
        logic [31:0] ea;
        for (int i = 0; i < n; i++) begin
            tick();
            eo = exp_out(k); er = exp_rf(k); ea = exp_addrs(k);
            n_vec++;
            if ({red, green, blue, de, hs, vs} !== eo) begin
                n_err++;
                $display("FAIL %s_out k=%0d got %h required %h", tag, k, {red, green, blue, de, hs, vs}, eo);
            end
            n_vec++;
            if ({region, fs} !== er) begin
                n_err++;
                $display("FAIL %s_region k=%0d got %b required %b", tag, k, {region, fs}, er);
            end
            n_vec++;
            if ({addr3, addr2, addr1, addr0} !== ea) begin
                n_err++;
                $display("FAIL %s_addr k=%0d got %h required %h", tag, k, {addr3, addr2, addr1, addr0}, ea);
            end
            if (rand_cfg && $urandom_range(0, 39) == 0) begin
                mode_cfg   = 8'($urandom);
                bin_thresh = 4'($urandom);
            end
        end
    endtask

    task automatic test_timing();
        fill_random();
        mode_cfg = 8'h94; bin_thresh = 4'd8;
        do_reset();
        test_timing_run(2 * FRAME + 4, 1'b0, "timing");
        $display("test_timing done k=%0d", k);
    endtask

    task automatic test_modes();
        fill_random();
        mode_cfg = 8'($urandom); bin_thresh = 4'($urandom);
        do_reset();
        test_timing_run(4 * FRAME, 1'b1, "modes");
        $display("test_modes done k=%0d", k);
    endtask

    task automatic test_known_values();
        int tk [8];
        logic [11:0] tv [8];
        for (int i = 0; i < QPIX; i++) begin
            mem[0][i] = 12'hF84; mem[1][i] = 12'hF84;
            mem[2][i] = 12'hFA4; mem[3][i] = 12'hFA4;
        end
        // frame 0 runs on reset shadow modes; frame 1 on all-binary thr 8
        tk[0] = 1 * HT + 1 + 2;  tv[0] = 12'hF84;
        tk[1] = 1 * HT + 9 + 2;  tv[1] = 12'h888;
        tk[2] = 5 * HT + 1 + 2;  tv[2] = 12'h999;
        tk[3] = 5 * HT + 9 + 2;  tv[3] = 12'hFFF;
        tk[4] = FRAME + tk[0];   tv[4] = 12'h000;
        tk[5] = FRAME + tk[1];   tv[5] = 12'h000;
        tk[6] = FRAME + tk[2];   tv[6] = 12'hFFF;
        tk[7] = FRAME + tk[3];   tv[7] = 12'hFFF;
        mode_cfg = 8'h94; bin_thresh = 4'd3;
        do_reset();
        mode_cfg = 8'hAA; bin_thresh = 4'd8;
        for (int i = 0; i < 8; i++) begin
            while (k < tk[i]) tick();
            n_vec++;
            if ({red, green, blue, de} !== {tv[i], 1'b1}) begin
                n_err++;
                $display("FAIL known_%0d k=%0d got %h required %h", i, k, {red, green, blue, de}, {tv[i], 1'b1});
            end
        end
        $display("test_known_values done");
    endtask

    task automatic test_midframe();
        int de_cnt;
        fill_random();
        mode_cfg = 8'h00; bin_thresh = 4'd5;
        do_reset();
        test_timing_run(FRAME / 2, 1'b0, "mid_a");
        mode_cfg = 8'hFF;
        test_timing_run(FRAME / 2 + 2, 1'b0, "mid_b");
        de_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (de === 1'b1) de_cnt++;
            n_vec++;
            if ({red, green, blue, de, hs, vs} !== exp_out(k)) begin
                n_err++;
                $display("FAIL mid_blank k=%0d got %h required %h", k, {red, green, blue, de, hs, vs}, exp_out(k));
            end
        end
        n_vec++;
        if (de_cnt !== HD * VD) begin
            n_err++;
            $display("FAIL mid_de_count got %0d required %0d", de_cnt, HD * VD);
        end
        $display("test_midframe done");
    endtask

    task automatic test_reset_midframe();
        fill_random();
        mode_cfg = 8'($urandom); bin_thresh = 4'($urandom);
        do_reset();
        test_timing_run(3 * HT + 10, 1'b0, "rstmid_pre");
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if ({red, green, blue, de, hs, vs} !== 15'b0000_0000_0000_0_1_1) begin
            n_err++;
            $display("FAIL rstmid_out got %h required %h", {red, green, blue, de, hs, vs}, 15'h0003);
        end
        n_vec++;
        if ({region, fs, addr3, addr2, addr1, addr0} !== {5'b0001_1, 32'h0}) begin
            n_err++;
            $display("FAIL rstmid_state got %b/%h required 00011/0", {region, fs}, {addr3, addr2, addr1, addr0});
        end
        do_reset();
        test_timing_run(FRAME + 4, 1'b0, "rstmid_post");
        $display("test_reset_midframe done");
    endtask

    initial begin
        for (int q = 0; q < 4; q++)
            for (int i = 0; i < QPIX; i++) mem[q][i] = 12'h000;
        test_reset();
        test_timing();
        test_known_values();
        test_modes();
        test_midframe();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
